// File: rtl/csoc_test_pkg.sv
// ============================================================================
// csoc_test_pkg : command codes, ACK/NAK bytes and FSM states of the scan engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package csoc_test_pkg;

  localparam logic [7:0] CMD_SCAN = 8'h53;  // 'S'
  localparam logic [7:0] CMD_CAP  = 8'h43;  // 'C'
  localparam logic [7:0] CMD_RST  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_TM   = 8'h54;  // 'T'
  localparam logic [7:0] CMD_CLR  = 8'h45;  // 'E'

  localparam logic [7:0] BYTE_ACK = 8'h06;
  localparam logic [7:0] BYTE_NAK = 8'h15;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    GET_CNT  = 4'd1,
    GET_DATA = 4'd2,
    GET_TM   = 4'd3,
    SETUP    = 4'd4,
    HI       = 4'd5,
    LO       = 4'd6,
    PUSH     = 4'd7,
    RST_HOLD = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/csoc_txfifo.sv
// ============================================================================
// csoc_txfifo : synchronous byte FIFO with full/empty flags, show-ahead read
// Revision: 1.0
// ============================================================================
`default_nettype none

module csoc_txfifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [7:0]  mem [DEPTH];

  // Extra pointer bit separates the full case from the empty case.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/csoc_scan_engine.sv
// ============================================================================
// csoc_scan_engine : UART byte-command engine driving the CSoC scan pins.
// Optional ACK/NAK reply bytes enabled by defining CSOC_SCAN_ACK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csoc_scan_engine
  import csoc_test_pkg::*;
#(
  parameter int CLK_HALF   = 4,
  parameter int RST_CYCLES = 16,
  parameter int TXF_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_rcv,
  input  logic [7:0] rx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       csoc_clk,
  output logic       csoc_rstn,
  output logic       csoc_test_se,
  output logic       csoc_test_tm,
  output logic [7:0] csoc_data_o,
  input  logic [7:0] csoc_data_i,
  output logic       busy,
  output logic       err_overrun
);

`ifdef CSOC_SCAN_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam int PH_MAX = (CLK_HALF > RST_CYCLES) ? CLK_HALF : RST_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(CLK_HALF - 1);
  localparam logic [PW-1:0] RST_LAST  = PW'(RST_CYCLES - 1);

  state_t        state;
  logic [PW-1:0] ph;
  logic [8:0]    cnt;
  logic          is_scan;
  logic [7:0]    cap;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_q;
  logic          pop;
  logic          push;
  logic          ph_last;
  logic          rx_ok;

  // Pop is evaluated before push, so a full FIFO still accepts a write
  // in a cycle that also drains it.
  assign pop     = !fifo_empty && tx_ready && !tx_start;
  assign push    = (state == PUSH) && (!fifo_full || pop);
  assign busy    = (state != IDLE);
  assign ph_last = (ph == HALF_LAST);
  assign rx_ok   = (state == IDLE) || (state == GET_CNT) ||
                   (state == GET_TM) || (state == GET_DATA);

  csoc_txfifo #(.DEPTH(TXF_DEPTH)) u_txfifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (cap),
    .pop       (pop),
    .pop_data  (fifo_q),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= pop;
      if (pop) tx_data <= fifo_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      ph           <= '0;
      cnt          <= 9'd0;
      is_scan      <= 1'b0;
      cap          <= 8'h00;
      csoc_clk     <= 1'b0;
      csoc_rstn    <= 1'b1;
      csoc_test_se <= 1'b0;
      csoc_test_tm <= 1'b0;
      csoc_data_o  <= 8'h00;
      err_overrun  <= 1'b0;
    end else begin
      if (rx_rcv && !rx_ok) err_overrun <= 1'b1;
      case (state)
        IDLE: if (rx_rcv) begin
          ph      <= '0;
          is_scan <= 1'b0;
          case (rx_data)
            CMD_SCAN: state <= GET_CNT;
            CMD_CAP:  state <= SETUP;
            CMD_RST:  begin csoc_rstn <= 1'b0; state <= RST_HOLD; end
            CMD_TM:   state <= GET_TM;
            CMD_CLR: begin
              err_overrun <= 1'b0;
              if (ACK_EN) begin cap <= BYTE_ACK; state <= PUSH; end
            end
            default: if (ACK_EN) begin cap <= BYTE_NAK; state <= PUSH; end
          endcase
        end
        GET_CNT: if (rx_rcv) begin
          cnt   <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          state <= GET_DATA;
        end
        GET_DATA: if (rx_rcv) begin
          csoc_data_o  <= rx_data;
          csoc_test_se <= 1'b1;
          is_scan      <= 1'b1;
          ph           <= '0;
          state        <= SETUP;
        end
        GET_TM: if (rx_rcv) begin
          csoc_test_tm <= rx_data[0];
          if (ACK_EN) begin cap <= BYTE_ACK; state <= PUSH; end
          else state <= IDLE;
        end
        SETUP: if (ph_last) begin
          cap      <= csoc_data_i;
          ph       <= '0;
          csoc_clk <= 1'b1;
          state    <= HI;
        end else ph <= ph + 1'b1;
        HI: if (ph_last) begin
          csoc_clk <= 1'b0;
          ph       <= '0;
          state    <= LO;
        end else ph <= ph + 1'b1;
        LO: if (ph_last) begin
          ph <= '0;
          if (is_scan) state <= PUSH;
          else if (ACK_EN) begin cap <= BYTE_ACK; state <= PUSH; end
          else state <= IDLE;
        end else ph <= ph + 1'b1;
        PUSH: if (push) begin
          if (is_scan && cnt != 9'd1) begin
            cnt   <= cnt - 9'd1;
            state <= GET_DATA;
          end else if (is_scan) begin
            // Last capture: the trailing ACK (if enabled) reuses this state.
            csoc_test_se <= 1'b0;
            is_scan      <= 1'b0;
            if (ACK_EN) cap <= BYTE_ACK;
            else state <= IDLE;
          end else state <= IDLE;
        end
        RST_HOLD: if (ph == RST_LAST) begin
          csoc_rstn <= 1'b1;
          if (ACK_EN) begin cap <= BYTE_ACK; state <= PUSH; end
          else state <= IDLE;
        end else ph <= ph + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csoc_scan_engine.sv
// ============================================================================
// tb_csoc_scan_engine : directed + randomized bench with a transaction-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_csoc_scan_engine;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_rcv = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b1;
  logic [7:0] csoc_data_i = 8'h00;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       csoc_clk;
  logic       csoc_rstn;
  logic       csoc_test_se;
  logic       csoc_test_tm;
  logic [7:0] csoc_data_o;
  logic       busy;
  logic       err_overrun;

  always #5 clk = ~clk;

  csoc_scan_engine #(.CLK_HALF(4), .RST_CYCLES(16), .TXF_DEPTH(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rx_rcv       (rx_rcv),
    .rx_data      (rx_data),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .csoc_clk     (csoc_clk),
    .csoc_rstn    (csoc_rstn),
    .csoc_test_se (csoc_test_se),
    .csoc_test_tm (csoc_test_tm),
    .csoc_data_o  (csoc_data_o),
    .csoc_data_i  (csoc_data_i),
    .busy         (busy),
    .err_overrun  (err_overrun)
  );

  int total = 0;
  int bad   = 0;

  // Observation of the pins: transmitted bytes, clock pulse widths, reset pulse widths.
  logic [7:0] txq[$];
  logic [7:0] exp_tx[$];
  int   hi_w[$];
  int   rlow[$];
  int   rise_cnt = 0;
  int   hi_run = 0;
  int   lo_run = 0;
  logic prev_clk = 1'b0;
  logic prev_rstn = 1'b1;

  always @(negedge clk) begin
    if (tx_start) txq.push_back(tx_data);
    if (csoc_clk) begin
      if (!prev_clk) rise_cnt = rise_cnt + 1;
      hi_run = hi_run + 1;
    end else begin
      if (prev_clk) hi_w.push_back(hi_run);
      hi_run = 0;
    end
    if (!csoc_rstn) lo_run = lo_run + 1;
    else begin
      if (!prev_rstn) rlow.push_back(lo_run);
      lo_run = 0;
    end
    prev_clk  = csoc_clk;
    prev_rstn = csoc_rstn;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_rcv  = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_rcv  = 1'b0;
  endtask

  task automatic exp_ack();
`ifdef CSOC_SCAN_ACK_EN
    exp_tx.push_back(8'h06);
`endif
  endtask

  task automatic check_tx(input string tag);
    chk({tag, "_count"}, 32'(txq.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
      chk({tag, "_byte"}, {24'h0, txq[i]}, {24'h0, exp_tx[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, w0, l0, n0, n;
    logic [7:0] v, b;

    cyc(3);
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_csoc_clk", {31'h0, csoc_clk}, 32'h0);
    chk("rst_csoc_rstn", {31'h0, csoc_rstn}, 32'h1);
    chk("rst_se", {31'h0, csoc_test_se}, 32'h0);
    chk("rst_tm", {31'h0, csoc_test_tm}, 32'h0);
    chk("rst_data_o", {24'h0, csoc_data_o}, 32'h0);
    chk("rst_err", {31'h0, err_overrun}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rstn = 1'b1;
    cyc(2);

    // Two-byte scan
    csoc_data_i = 8'h5A;
    r0 = rise_cnt;
    w0 = hi_w.size();
    send(8'h53); send(8'h02); send(8'hA5);
    chk("scan_data0", {24'h0, csoc_data_o}, 32'hA5);
    chk("scan_se0", {31'h0, csoc_test_se}, 32'h1);
    chk("scan_busy", {31'h0, busy}, 32'h1);
    cyc(16);
    send(8'h3C);
    chk("scan_data1", {24'h0, csoc_data_o}, 32'h3C);
    chk("scan_se1", {31'h0, csoc_test_se}, 32'h1);
    cyc(20);
    chk("scan_se_end", {31'h0, csoc_test_se}, 32'h0);
    chk("scan_idle", {31'h0, busy}, 32'h0);
    chk("scan_pulses", 32'(rise_cnt - r0), 32'd2);
    chk("scan_widths", 32'(hi_w.size() - w0), 32'd2);
    chk("scan_hi_w0", 32'(hi_w[w0]), 32'd4);
    chk("scan_hi_w1", 32'(hi_w[w0 + 1]), 32'd4);
    exp_tx.push_back(8'h5A); exp_tx.push_back(8'h5A); exp_ack();
    check_tx("scan1");

    // Target reset pulse
    l0 = rlow.size();
    send(8'h52);
    chk("rst_cmd_low", {31'h0, csoc_rstn}, 32'h0);
    chk("rst_cmd_busy", {31'h0, busy}, 32'h1);
    cyc(24);
    chk("rst_cmd_pulses", 32'(rlow.size() - l0), 32'd1);
    chk("rst_cmd_len", 32'(rlow[$]), 32'd16);
    chk("rst_cmd_high", {31'h0, csoc_rstn}, 32'h1);
    chk("rst_cmd_idle", {31'h0, busy}, 32'h0);
    exp_ack();
    check_tx("rst");

    // Test mode, functional capture, unknown byte
    send(8'h54); send(8'h01);
    chk("tm_set", {31'h0, csoc_test_tm}, 32'h1);
    cyc(4); exp_ack();
    send(8'h54); send(8'h00);
    chk("tm_clr", {31'h0, csoc_test_tm}, 32'h0);
    chk("tm_se", {31'h0, csoc_test_se}, 32'h0);
    cyc(4); exp_ack();
    r0 = rise_cnt;
    send(8'h43);
    chk("cap_se", {31'h0, csoc_test_se}, 32'h0);
    cyc(16);
    chk("cap_pulses", 32'(rise_cnt - r0), 32'd1);
    chk("cap_idle", {31'h0, busy}, 32'h0);
    exp_ack();
    send(8'h5A);
    cyc(6);
    chk("unk_idle", {31'h0, busy}, 32'h0);
`ifdef CSOC_SCAN_ACK_EN
    exp_tx.push_back(8'h15);
`endif
    check_tx("cmds");

    // Overrun during HI
    v = 8'($urandom);
    csoc_data_i = v;
    send(8'h53); send(8'h01); send(8'h11);
    cyc(4);
    send(8'h77);
    chk("ovr_clk_hi", {31'h0, csoc_clk}, 32'h1);
    chk("ovr_flag", {31'h0, err_overrun}, 32'h1);
    chk("ovr_data_o", {24'h0, csoc_data_o}, 32'h11);
    cyc(16);
    chk("ovr_sticky", {31'h0, err_overrun}, 32'h1);
    chk("ovr_idle", {31'h0, busy}, 32'h0);
    exp_tx.push_back(v); exp_ack();
    check_tx("ovr");
    send(8'h45);
    chk("ovr_clear", {31'h0, err_overrun}, 32'h0);
    cyc(4); exp_ack();

    // Back-pressure: FIFO fills, fifth capture stalls
    tx_ready = 1'b0;
    n0 = txq.size();
    send(8'h53); send(8'h05);
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      csoc_data_i = v;
      exp_tx.push_back(v);
      send(8'($urandom));
      cyc(16);
    end
    chk("stall_busy", {31'h0, busy}, 32'h1);
    chk("stall_se", {31'h0, csoc_test_se}, 32'h1);
    chk("stall_no_tx", 32'(txq.size()), 32'(n0));
    tx_ready = 1'b1;
    cyc(30);
    chk("stall_idle", {31'h0, busy}, 32'h0);
    chk("stall_se_end", {31'h0, csoc_test_se}, 32'h0);
    exp_ack();
    check_tx("stall");

    // Reset during HI flushes everything
    tx_ready = 1'b0;
    send(8'h53); send(8'h02);
    csoc_data_i = 8'($urandom);
    send(8'($urandom));
    cyc(16);
    send(8'($urandom));
    cyc(5);
    chk("mid_clk_hi", {31'h0, csoc_clk}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_clk", {31'h0, csoc_clk}, 32'h0);
    chk("mid_rst_se", {31'h0, csoc_test_se}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_data_o", {24'h0, csoc_data_o}, 32'h0);
    cyc(2);
    rstn = 1'b1;
    tx_ready = 1'b1;
    cyc(10);
    check_tx("flush");
    send(8'h54); send(8'h01);
    chk("post_rst_tm", {31'h0, csoc_test_tm}, 32'h1);
    cyc(4); exp_ack();
    check_tx("post_rst");

    // Randomized scans
    for (int r = 0; r < 4; r++) begin
      n = int'($urandom_range(1, 3));
      send(8'h53); send(8'(n));
      for (int i = 0; i < n; i++) begin
        v = 8'($urandom);
        b = 8'($urandom);
        csoc_data_i = v;
        exp_tx.push_back(v);
        send(b);
        chk("rnd_data_o", {24'h0, csoc_data_o}, {24'h0, b});
        cyc(16);
      end
      cyc(8);
      exp_ack();
      chk("rnd_idle", {31'h0, busy}, 32'h0);
    end
    check_tx("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
